fa_bist_ctrl: RTL and testbench

//  Built-in self-test controller for a 1-bit full adder: the response side of the full-adder interface.

---
 rtl/fa_bist_pkg.sv | 27 ++
 rtl/fa_bist_if.sv | 48 ++++
 rtl/fa_bist_misr.sv | 34 +++
 rtl/fa_bist_ctrl.sv | 158 +++++++++++++++
 tb/tb_fa_bist_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fa_bist_pkg.sv
// Shared constants and golden model for the full-adder BIST controller.
// FSM encodings, vector count, MISR polynomial/seed, fa_expect().
package fa_bist_pkg;

    localparam int NUM_VECS = 8;

    typedef logic [2:0] vec_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [1:0] fa_expect(
        input logic a,
        input logic b,
        input logic c
    );
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

endpackage

// File: rtl/fa_bist_if.sv
// Sequencer / adder-facing bundle of the BIST controller.
// signature exists only when FA_BIST_MISR_EN is defined.
interface fa_bist_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [2:0]       fail_vec;
    logic             dut_a;
    logic             dut_b;
    logic             dut_c;
    logic             dut_sum;
    logic             dut_carry;
`ifdef FA_BIST_MISR_EN
    logic [15:0]      signature;

    modport master (
        output start, abort, dut_sum, dut_carry,
        input  busy, done, pass, err_cnt,
        input  fail_valid, fail_vec,
        input  dut_a, dut_b, dut_c, signature
    );
    modport slave (
        input  start, abort, dut_sum, dut_carry,
        output busy, done, pass, err_cnt,
        output fail_valid, fail_vec,
        output dut_a, dut_b, dut_c, signature
    );
`else
    modport master (
        output start, abort, dut_sum, dut_carry,
        input  busy, done, pass, err_cnt,
        input  fail_valid, fail_vec,
        input  dut_a, dut_b, dut_c
    );
    modport slave (
        input  start, abort, dut_sum, dut_carry,
        output busy, done, pass, err_cnt,
        output fail_valid, fail_vec,
        output dut_a, dut_b, dut_c
    );
`endif
endinterface

// File: rtl/fa_bist_misr.sv
// 16-bit MISR compacting {carry,sum} responses of the adder under test.
// Data is folded into bits [1:0], then one Galois LFSR step.
module fa_bist_misr
    import fa_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_seed,
    input  logic        i_shift,
    input  logic [1:0]  i_data,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;
    logic [15:0] w_mix;
    logic [15:0] w_next;

    assign w_mix  = r_sig ^ {14'd0, i_data};
    assign w_next = {w_mix[14:0], 1'b0}
                  ^ (w_mix[15] ? MISR_POLY : 16'h0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= 16'h0000;
        end else if (i_seed) begin
            r_sig <= MISR_SEED;
        end else if (i_shift) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/fa_bist_ctrl.sv
// Exhaustive 8-vector BIST controller for a 1-bit full adder.
// Optional signature MISR enabled by defining FA_BIST_MISR_EN.
module fa_bist_ctrl
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input logic      clk,
    input logic      rst,
    fa_bist_if.slave bus
);

    localparam int WAIT_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W =
        (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST =
        PASS_W'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam vec_t LAST_VEC = vec_t'(NUM_VECS - 1);

    logic [2:0]        r_state;
    vec_t              r_idx;
    logic [PASS_W-1:0] r_pass_idx;
    logic [WAIT_W-1:0] r_wait;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_fail_valid;
    vec_t              r_fail_vec;

    logic             w_vec_on;
    logic             w_start_acc;
    logic             w_abort;
    logic [1:0]       w_exp;
    logic             w_miss;
    logic [ERR_W-1:0] w_err_nxt;

    assign w_vec_on = (r_state == S_DRIVE)
                   || (r_state == S_WAIT)
                   || (r_state == S_SAMPLE);
    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    assign w_abort     = w_vec_on && bus.abort;

    assign w_exp  = fa_expect(r_idx[2], r_idx[1], r_idx[0]);
    assign w_miss = (r_state == S_SAMPLE)
                 && ({bus.dut_sum, bus.dut_carry} != w_exp);
    assign w_err_nxt = (w_miss && (r_err_cnt != ERR_MAX))
                     ? r_err_cnt + ERR_W'(1) : r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_pass_idx   <= '0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else if (w_abort) begin
            // partial err_cnt / fail_* stay visible after a cancel
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state      <= S_DRIVE;
                        r_idx        <= '0;
                        r_pass_idx   <= '0;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                    end
                end
                S_DRIVE: begin
                    r_state <= S_WAIT;
                    r_wait  <= '0;
                end
                S_WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_err_cnt <= w_err_nxt;
                    if (w_miss && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_vec   <= r_idx;
                    end
                    if (r_idx != LAST_VEC) begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= S_DRIVE;
                    end else if (r_pass_idx != PASS_LAST) begin
                        r_idx      <= '0;
                        r_pass_idx <= r_pass_idx + PASS_W'(1);
                        r_state    <= S_DRIVE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_nxt == '0);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_a      = w_vec_on & r_idx[2];
    assign bus.dut_b      = w_vec_on & r_idx[1];
    assign bus.dut_c      = w_vec_on & r_idx[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_vec   = r_fail_vec;

`ifdef FA_BIST_MISR_EN
    logic        w_shift;
    logic [15:0] w_sig;

    assign w_shift = (r_state == S_SAMPLE) && !bus.abort;

    fa_bist_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .i_seed  (w_start_acc),
        .i_shift (w_shift),
        .i_data  ({bus.dut_carry, bus.dut_sum}),
        .o_sig   (w_sig)
    );

    assign bus.signature = w_sig;
`endif

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Directed bench for fa_bist_ctrl with behavioural faulty adders.
// MISR scenario compiled only with FA_BIST_MISR_EN.
module tb_fa_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   fault1 = 0;
    int   fault2 = 0;
    int   cyc = 0;
    int   cyc2 = 0;

    always #5 clk = ~clk;

    fa_bist_if #(.ERR_W(4)) bus1 ();
    fa_bist_if #(.ERR_W(4)) bus2 ();

    fa_bist_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fa_bist_ctrl #(
        .SETTLE_CYCLES (1),
        .NUM_PASSES    (2),
        .ERR_W         (4)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // 0 good, 1 carry stuck-0, 2 sum inverted, 3 sum stuck-1
    function automatic logic [1:0] adder(input logic [2:0] v, input int f);
        logic s;
        logic c;
        s = v[2] ^ v[1] ^ v[0];
        c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        if (f == 1) c = 1'b0;
        if (f == 2) s = ~s;
        if (f == 3) s = 1'b1;
        return {s, c};
    endfunction

    assign {bus1.dut_sum, bus1.dut_carry} =
        adder({bus1.dut_a, bus1.dut_b, bus1.dut_c}, fault1);
    assign {bus2.dut_sum, bus2.dut_carry} =
        adder({bus2.dut_a, bus2.dut_b, bus2.dut_c}, fault2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done1(input int lim);
        while (bus1.done !== 1'b1 && cyc < lim) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;
        rst = 1'b1;
        tick(); tick();
        total++;
        if ({bus1.busy, bus1.done, bus1.pass, bus1.fail_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got %b want 0000",
                {bus1.busy, bus1.done, bus1.pass, bus1.fail_valid});
        end
        total++;
        if ({bus1.err_cnt, bus1.fail_vec} !== 7'd0) begin
            bad++; $display("FAIL reset_cnt got err=%0d vec=%b want 0/000",
                bus1.err_cnt, bus1.fail_vec);
        end
        total++;
        if ({bus1.dut_a, bus1.dut_b, bus1.dut_c} !== 3'b000) begin
            bad++; $display("FAIL reset_abc got %b want 000",
                {bus1.dut_a, bus1.dut_b, bus1.dut_c});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good();
        fault1 = 0;
        start1();
        total++;
        if (bus1.busy !== 1'b1) begin
            bad++; $display("FAIL good_busy got %b want 1", bus1.busy);
        end
        wait_done1(100);
        total++;
        if (cyc != 24) begin
            bad++; $display("FAIL good_latency got %0d want 24", cyc);
        end
        total++;
        if ({bus1.pass, bus1.fail_valid, bus1.busy} !== 3'b100) begin
            bad++; $display("FAIL good_flags got %b want 100",
                {bus1.pass, bus1.fail_valid, bus1.busy});
        end
        total++;
        if (bus1.err_cnt !== 4'd0) begin
            bad++; $display("FAIL good_err got %0d want 0", bus1.err_cnt);
        end
        tick();
        total++;
        if (bus1.done !== 1'b0) begin
            bad++; $display("FAIL good_done_pulse got %b want 0", bus1.done);
        end
    endtask

    task automatic test_abort_idle();
        bus1.abort = 1'b1;
        tick(); tick();
        bus1.abort = 1'b0;
        total++;
        if ({bus1.pass, bus1.busy} !== 2'b10) begin
            bad++; $display("FAIL idle_abort got %b want 10",
                {bus1.pass, bus1.busy});
        end
    endtask

    task automatic test_carry_stuck();
        fault1 = 1;
        start1();
        wait_done1(100);
        total++;
        if (cyc != 24) begin
            bad++; $display("FAIL carry_latency got %0d want 24", cyc);
        end
        total++;
        if (bus1.err_cnt !== 4'd4) begin
            bad++; $display("FAIL carry_err got %0d want 4", bus1.err_cnt);
        end
        total++;
        if ({bus1.fail_valid, bus1.fail_vec, bus1.pass} !== 5'b1_011_0) begin
            bad++; $display("FAIL carry_vec got v=%b vec=%b pass=%b want 1/011/0",
                bus1.fail_valid, bus1.fail_vec, bus1.pass);
        end
        tick();
    endtask

    task automatic test_busy_abort();
        int seen;
        fault1 = 1;
        start1();
        for (int k = 1; k <= 13; k++) begin
            bus1.start = (k == 5);
            tick();
        end
        bus1.start = 1'b0;
        total++;
        if ({bus1.busy, bus1.dut_a, bus1.dut_b, bus1.dut_c} !== 4'b1100) begin
            bad++; $display("FAIL busy_restart got busy/abc=%b want 1100",
                {bus1.busy, bus1.dut_a, bus1.dut_b, bus1.dut_c});
        end
        bus1.abort = 1'b1;
        tick();
        bus1.abort = 1'b0;
        total++;
        if ({bus1.busy, bus1.done, bus1.pass} !== 3'b000) begin
            bad++; $display("FAIL abort_flags got %b want 000",
                {bus1.busy, bus1.done, bus1.pass});
        end
        total++;
        if ({bus1.err_cnt, bus1.fail_valid, bus1.fail_vec} !== 8'b0001_1_011) begin
            bad++; $display("FAIL abort_partial got err=%0d v=%b vec=%b want 1/1/011",
                bus1.err_cnt, bus1.fail_valid, bus1.fail_vec);
        end
        total++;
        if ({bus1.dut_a, bus1.dut_b, bus1.dut_c} !== 3'b000) begin
            bad++; $display("FAIL abort_abc got %b want 000",
                {bus1.dut_a, bus1.dut_b, bus1.dut_c});
        end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus1.done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL abort_no_done got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_saturate();
        fault2 = 2;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        cyc2 = 0;
        while (bus2.done !== 1'b1 && cyc2 < 200) begin
            tick();
            cyc2++;
        end
        total++;
        if (cyc2 != 48) begin
            bad++; $display("FAIL sat_latency got %0d want 48", cyc2);
        end
        total++;
        if (bus2.err_cnt !== 4'd15) begin
            bad++; $display("FAIL sat_err got %0d want 15", bus2.err_cnt);
        end
        total++;
        if ({bus2.fail_valid, bus2.fail_vec, bus2.pass} !== 5'b1_000_0) begin
            bad++; $display("FAIL sat_vec got v=%b vec=%b pass=%b want 1/000/0",
                bus2.fail_valid, bus2.fail_vec, bus2.pass);
        end
        tick();
    endtask

    task automatic test_async_reset();
        fault1 = 2;
        start1();
        repeat (10) tick();
        total++;
        if (bus1.err_cnt !== 4'd3) begin
            bad++; $display("FAIL rst_pre_err got %0d want 3", bus1.err_cnt);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus1.busy, bus1.done, bus1.pass, bus1.fail_valid} !== 4'b0) begin
            bad++; $display("FAIL rst_async_flags got %b want 0000",
                {bus1.busy, bus1.done, bus1.pass, bus1.fail_valid});
        end
        total++;
        if ({bus1.err_cnt, bus1.fail_vec,
             bus1.dut_a, bus1.dut_b, bus1.dut_c} !== 10'd0) begin
            bad++; $display("FAIL rst_async_data got err=%0d vec=%b abc=%b want 0",
                bus1.err_cnt, bus1.fail_vec,
                {bus1.dut_a, bus1.dut_b, bus1.dut_c});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        fault1 = 0;
        start1();
        wait_done1(100);
        total++;
        if (cyc != 24 || bus1.pass !== 1'b1 || bus1.err_cnt !== 4'd0) begin
            bad++; $display("FAIL rst_fresh got cyc=%0d pass=%b err=%0d want 24/1/0",
                cyc, bus1.pass, bus1.err_cnt);
        end
        tick();
    endtask

`ifdef FA_BIST_MISR_EN
    function automatic logic [15:0] misr_ref(input int f);
        logic [15:0] s;
        logic [1:0]  r;
        logic        fb;
        s = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            r = adder(3'(i), f);
            s = s ^ {14'd0, r[0], r[1]};
            fb = s[15];
            s = {s[14:0], 1'b0};
            if (fb) s = s ^ 16'h1021;
        end
        return s;
    endfunction

    task automatic test_misr();
        logic [15:0] good_sig;
        logic [15:0] bad_sig;
        fault1 = 0;
        start1();
        wait_done1(100);
        good_sig = bus1.signature;
        total++;
        if (good_sig !== misr_ref(0)) begin
            bad++; $display("FAIL misr_good got %h want %h",
                good_sig, misr_ref(0));
        end
        repeat (3) tick();
        total++;
        if (bus1.signature !== good_sig) begin
            bad++; $display("FAIL misr_hold got %h want %h",
                bus1.signature, good_sig);
        end
        fault1 = 3;
        start1();
        wait_done1(100);
        bad_sig = bus1.signature;
        total++;
        if (bad_sig !== misr_ref(3) || bad_sig === good_sig) begin
            bad++; $display("FAIL misr_faulty got %h want %h (good %h)",
                bad_sig, misr_ref(3), good_sig);
        end
        total++;
        if (bus1.err_cnt !== 4'd4 || bus1.fail_vec !== 3'b000) begin
            bad++; $display("FAIL misr_faulty_err got %0d/%b want 4/000",
                bus1.err_cnt, bus1.fail_vec);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_good();
        test_abort_idle();
        test_carry_stuck();
        test_busy_abort();
        test_saturate();
        test_async_reset();
`ifdef FA_BIST_MISR_EN
        test_misr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
